// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - RISC-V memory-access and writeback stage
module mem_wb_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_wreg,
  input  logic [RADDR_W-1:0] in_wd,
  input  logic [XLEN-1:0]    in_result,
  input  logic               in_ld,
  input  logic               in_st,
  input  logic [2:0]         in_funct3,
  input  logic [XLEN-1:0]    in_sdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [XLEN-1:0]    mem_addr,
  output logic [3:0]         mem_be,
  output logic [XLEN-1:0]    mem_wdata,
  input  logic               mem_ack,
  input  logic [XLEN-1:0]    mem_rdata,
  output logic               wb_we,
  output logic [RADDR_W-1:0] wb_waddr,
  output logic [XLEN-1:0]    wb_wdata,
  output logic               exc_misalign
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MEM  = 1'b1;

  logic [0:0]         state;
  logic [2:0]         ld_funct3;
  logic [1:0]         ld_off;
  logic               ld_wb;
  logic [RADDR_W-1:0] ld_rd;

  logic            accept;
  logic            is_mem;
  logic            f3_ok;
  logic            misalign;
  logic            bad;
  logic            rd_write;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_data;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] ld_val;

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign is_mem   = in_ld || in_st;
  assign mem_req  = (state == MEM);
  assign rd_write = in_wreg && (in_wd != '0);
  assign misalign = ((in_funct3[1:0] == 2'b01) && in_result[0]) ||
                    ((in_funct3[1:0] == 2'b10) && (in_result[1:0] != 2'b00));
  assign bad      = is_mem && (!f3_ok || misalign);

  always_comb begin
    f3_ok = 1'b0;
    if (in_ld) begin
      case (in_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
        default:                                f3_ok = 1'b0;
      endcase
    end else begin
      f3_ok = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010);
    end
  end

  // Store lanes are replicated so the memory only needs the byte enables.
  always_comb begin
    st_be   = 4'b1111;
    st_data = in_sdata;
    case (in_funct3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << in_result[1:0];
        st_data = {(XLEN/8){in_sdata[7:0]}};
      end
      2'b01: begin
        st_be   = 4'b0011 << {in_result[1], 1'b0};
        st_data = {(XLEN/16){in_sdata[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = in_sdata;
      end
    endcase
  end

  always_comb begin
    lane   = mem_rdata >> {ld_off, 3'b000};
    ld_val = lane;
    case (ld_funct3)
      3'b000:  ld_val = {{(XLEN-8){lane[7]}}, lane[7:0]};
      3'b001:  ld_val = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'b100:  ld_val = {{(XLEN-8){1'b0}}, lane[7:0]};
      3'b101:  ld_val = {{(XLEN-16){1'b0}}, lane[15:0]};
      default: ld_val = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= 4'b0000;
      mem_wdata    <= '0;
      wb_we        <= 1'b0;
      wb_waddr     <= '0;
      wb_wdata     <= '0;
      exc_misalign <= 1'b0;
      ld_funct3    <= 3'b000;
      ld_off       <= 2'b00;
      ld_wb        <= 1'b0;
      ld_rd        <= '0;
    end else begin
      wb_we        <= 1'b0;
      exc_misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              if (rd_write) begin
                wb_we    <= 1'b1;
                wb_waddr <= in_wd;
                wb_wdata <= in_result;
              end
            end else if (bad) begin
              exc_misalign <= 1'b1;
            end else begin
              state     <= MEM;
              mem_we    <= in_st;
              mem_addr  <= {in_result[XLEN-1:2], 2'b00};
              mem_be    <= in_st ? st_be : 4'b1111;
              mem_wdata <= st_data;
              ld_funct3 <= in_funct3;
              ld_off    <= in_result[1:0];
              ld_wb     <= in_ld && rd_write;
              ld_rd     <= in_wd;
            end
          end
        end
        default: begin
          if (mem_ack) begin
            state <= IDLE;
            if (ld_wb) begin
              wb_we    <= 1'b1;
              wb_waddr <= ld_rd;
              wb_wdata <= ld_val;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - randomized and directed bench for mem_wb_stage
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_wreg;
  logic [4:0]  in_wd;
  logic [31:0] in_result;
  logic        in_ld;
  logic        in_st;
  logic [2:0]  in_funct3;
  logic [31:0] in_sdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        exc_misalign;

  int checks   = 0;
  int failures = 0;

  mem_wb_stage #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_wreg(in_wreg), .in_wd(in_wd),
    .in_result(in_result), .in_ld(in_ld), .in_st(in_st), .in_funct3(in_funct3),
    .in_sdata(in_sdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .exc_misalign(exc_misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: one outstanding access plus last writeback.
  bit          busy;
  bit          p_ld, p_st, p_wb;
  logic [2:0]  p_f3;
  logic [31:0] p_addr;
  logic [4:0]  p_rd;
  logic        e_wb_we, e_exc, e_we, fresh_rst;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata, e_addr, e_mwd;
  logic [3:0]  e_be;

  function automatic bit legal(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    bit ok;
    ok = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    sz = 1 << f3[1:0];
    return ok && ((a % sz) == 0);
  endfunction

  function automatic logic [31:0] load_value(input logic [31:0] rd, input logic [2:0] f3,
                                              input logic [31:0] a);
    int sz;
    logic [31:0] v;
    sz = 1 << f3[1:0];
    v  = rd >> (8 * (a % 4));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (!f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] sd, input logic [2:0] f3);
    int sz;
    logic [31:0] w;
    sz = 1 << f3[1:0];
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz) +: 8];
    return w;
  endfunction

  task automatic model_edge();
    e_wb_we   = 1'b0;
    e_exc     = 1'b0;
    fresh_rst = 1'b0;
    if (rst) begin
      busy = 0; fresh_rst = 1'b1;
      e_we = 0; e_addr = 0; e_be = 0; e_mwd = 0; e_waddr = 0; e_wdata = 0;
    end else if (busy) begin
      if (mem_ack) begin
        busy = 0;
        if (p_wb) begin
          e_wb_we = 1'b1; e_waddr = p_rd; e_wdata = load_value(mem_rdata, p_f3, p_addr);
        end
      end
    end else if (in_valid) begin
      if (!in_ld && !in_st) begin
        if (in_wreg && in_wd != 0) begin
          e_wb_we = 1'b1; e_waddr = in_wd; e_wdata = in_result;
        end
      end else if (!legal(in_ld, in_funct3, in_result)) begin
        e_exc = 1'b1;
      end else begin
        busy = 1; p_ld = in_ld; p_st = in_st; p_f3 = in_funct3; p_addr = in_result;
        p_rd = in_wd; p_wb = in_ld && in_wreg && (in_wd != 0);
        e_we   = in_st;
        e_addr = in_result & 32'hFFFF_FFFC;
        e_be   = in_st ? 4'(((1 << (1 << in_funct3[1:0])) - 1) << (in_result % 4)) : 4'hF;
        e_mwd  = lanes(in_sdata, in_funct3);
      end
    end
  endtask

  task automatic step();
    #1;
    check("in_ready", {31'b0, in_ready}, {31'b0, !busy && !rst});
    model_edge();
    @(posedge clk);
    #1;
    check("mem_req", {31'b0, mem_req}, {31'b0, busy});
    check("wb_we", {31'b0, wb_we}, {31'b0, e_wb_we});
    check("wb_waddr", {27'b0, wb_waddr}, {27'b0, e_waddr});
    check("wb_wdata", wb_wdata, e_wdata);
    check("exc_misalign", {31'b0, exc_misalign}, {31'b0, e_exc});
    if (busy || fresh_rst) begin
      check("mem_we", {31'b0, mem_we}, {31'b0, e_we});
      check("mem_addr", mem_addr, e_addr);
      check("mem_be", {28'b0, mem_be}, {28'b0, e_be});
      if (fresh_rst || p_st) check("mem_wdata", mem_wdata, e_mwd);
    end
  endtask

  task automatic set_idle();
    in_valid = 0; in_ld = 0; in_st = 0; in_wreg = 0;
  endtask

  task automatic set_alu(input logic [4:0] wd, input logic [31:0] res);
    in_valid = 1; in_ld = 0; in_st = 0; in_wreg = 1; in_wd = wd; in_result = res;
  endtask

  task automatic set_mem(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] wd);
    in_valid = 1; in_ld = ld; in_st = !ld; in_funct3 = f3; in_result = a;
    in_sdata = sd; in_wreg = ld; in_wd = wd;
  endtask

  task automatic ack_after(input int waits, input logic [31:0] rd);
    set_idle();
    mem_ack = 0;
    for (int i = 0; i < waits; i++) step();
    mem_ack = 1; mem_rdata = rd;
    step();
    mem_ack = 0;
  endtask

  task automatic load_test(input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rd, input logic [31:0] want, input string tag);
    set_mem(1, f3, a, 0, 5'd7);
    step();
    check({tag, "_addr"}, mem_addr, a & 32'hFFFF_FFFC);
    check({tag, "_be"}, {28'b0, mem_be}, 32'hF);
    ack_after(2, rd);
    check({tag, "_we"}, {31'b0, wb_we}, 32'd1);
    check({tag, "_data"}, wb_wdata, want);
  endtask

  initial begin
    busy = 0; p_ld = 0; p_st = 0; p_wb = 0; p_f3 = 0; p_addr = 0; p_rd = 0;
    e_wb_we = 0; e_exc = 0; e_we = 0; e_waddr = 0; e_wdata = 0; e_addr = 0;
    e_mwd = 0; e_be = 0; fresh_rst = 0;
    rst = 1; in_valid = 0; in_wreg = 0; in_wd = 0; in_result = 0; in_ld = 0;
    in_st = 0; in_funct3 = 0; in_sdata = 0; mem_ack = 0; mem_rdata = 0;
    step(); step();
    rst = 0;
    #1;
    check("reset_ready", {31'b0, in_ready}, 32'd1);
    check("reset_req", {31'b0, mem_req}, 32'd0);

    // reset during an outstanding load, late ack must be ignored
    set_mem(1, 3'd2, 32'h10, 0, 5'd5);
    step();
    check("rst_req_up", {31'b0, mem_req}, 32'd1);
    set_idle(); step();
    rst = 1; step();
    check("rst_req_drop", {31'b0, mem_req}, 32'd0);
    step();
    rst = 0; mem_ack = 1; mem_rdata = 32'h1234_5678;
    step();
    mem_ack = 0;
    check("rst_no_wb", {31'b0, wb_we}, 32'd0);
    check("rst_ready", {31'b0, in_ready}, 32'd1);

    // back-to-back ALU ops
    set_alu(5'd1, 32'h11); step();
    check("alu1_we", {31'b0, wb_we}, 32'd1);
    check("alu1_data", wb_wdata, 32'h11);
    set_alu(5'd2, 32'h22); step();
    check("alu2_addr", {27'b0, wb_waddr}, 32'd2);
    check("alu2_data", wb_wdata, 32'h22);
    set_alu(5'd0, 32'h33); step();
    check("alu0_we", {31'b0, wb_we}, 32'd0);
    check("alu0_hold", wb_wdata, 32'h22);
    set_idle(); step();

    load_test(3'd0, 32'h103, 32'h80FF_7F01, 32'hFFFF_FF80, "lb");
    load_test(3'd4, 32'h103, 32'h80FF_7F01, 32'h0000_0080, "lbu");
    load_test(3'd1, 32'h202, 32'h8001_1234, 32'hFFFF_8001, "lh");
    load_test(3'd2, 32'h204, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "lw");

    set_mem(0, 3'd0, 32'h301, 32'h1234_56AB, 5'd3); step();
    check("sb_be", {28'b0, mem_be}, 32'h2);
    check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    check("sb_we", {31'b0, mem_we}, 32'd1);
    ack_after(0, 32'h0);
    check("sb_no_wb", {31'b0, wb_we}, 32'd0);
    set_mem(0, 3'd1, 32'h302, 32'h1234_56AB, 5'd3); step();
    check("sh_be", {28'b0, mem_be}, 32'hC);
    check("sh_wdata", mem_wdata, 32'h56AB_56AB);
    ack_after(1, 32'h0);

    set_mem(1, 3'd2, 32'h402, 0, 5'd4); step();
    check("mis_exc", {31'b0, exc_misalign}, 32'd1);
    check("mis_req", {31'b0, mem_req}, 32'd0);
    set_idle(); step();
    check("mis_pulse", {31'b0, exc_misalign}, 32'd0);
    set_mem(1, 3'd3, 32'h400, 0, 5'd4); step();
    check("ill_exc", {31'b0, exc_misalign}, 32'd1);
    check("ill_wb", {31'b0, wb_we}, 32'd0);
    set_idle(); step();

    for (int n = 0; n < 3000; n++) begin
      int kind;
      rst       = ($urandom_range(0, 99) == 0);
      kind      = $urandom_range(0, 2);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_ld     = (kind == 1);
      in_st     = (kind == 2);
      in_funct3 = 3'($urandom_range(0, 7));
      in_result = $urandom;
      in_sdata  = $urandom;
      in_wreg   = 1'($urandom_range(0, 1));
      in_wd     = 5'($urandom_range(0, 31));
      mem_ack   = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      step();
    end
    rst = 0; set_idle(); mem_ack = 1;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access and writeback stage of the RISC-V pipeline. It sits between the execute stage and the register file write port.
- Accepts one executed instruction per cycle and performs any load or store over a variable-latency data-memory handshake.
- Aligns and sign- or zero-extends load data, then drives the register file write port (we/waddr/wdata) for exactly one cycle per writing instruction.
- Stalls upstream while a memory access is outstanding.

Parameters:
- XLEN, 32, data/address width
- RADDR_W, 5, register address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_wreg  in  1  instruction writes rd
- in_wd  in  RADDR_W  destination register rd
- in_result  in  XLEN  ALU result; this is the effective address for ld/st
- in_ld  in  1  load instruction
- in_st  in  1  store instruction (in_ld and in_st are never both 1)
- in_funct3  in  3  load/store width code
- in_sdata  in  XLEN  store data (rs2)
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = store
- mem_addr  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  XLEN  lane-replicated store data
- mem_ack  in  1  memory completes the request this cycle
- mem_rdata  in  XLEN  read word, valid when mem_ack=1
- wb_we  out  1  register file write enable
- wb_waddr  out  RADDR_W  register file write address
- wb_wdata  out  XLEN  register file write data
- exc_misalign  out  1  one-cycle pulse: misaligned or illegal-funct3 access

Behaviour:
- Reset: on rst=1 at a clock edge, state goes to IDLE. All of the following are 0 on the next cycle: mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_we, wb_waddr, wb_wdata, exc_misalign. in_ready=1 after reset.
- Reset mid-access: mem_req drops the cycle after rst. A mem_ack arriving later is ignored and produces no writeback.
- States: IDLE and MEM. in_ready = (state==IDLE) && !rst. An instruction is accepted on a cycle where in_valid && in_ready.
- Non-memory instruction accepted at cycle T:
  - At T+1: wb_we = in_wreg && (in_wd!=0), wb_waddr=in_wd, wb_wdata=in_result.
  - Stays in IDLE, giving back-to-back throughput of 1 per cycle.
- Width codes:
  - Load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Store: 000 SB, 001 SH, 010 SW.
  - Any other code on a load/store is illegal.
- Misaligned access: H with addr[0]=1, or W with addr[1:0]!=0.
- Illegal or misaligned load/store accepted at T: exc_misalign=1 at T+1 only. No mem_req, no writeback, state stays IDLE.
- Legal load/store accepted at T:
  - At T+1: state=MEM, mem_req=1. mem_addr, mem_be and mem_wdata are registered and held stable until ack. in_ready=0.
  - On the cycle mem_ack=1 while mem_req=1, the access completes and the state returns to IDLE next cycle. The earliest completion is mem_ack at T+1, giving in_ready=1 at T+2.
  - mem_req deasserts the cycle after ack.
- Store outputs:
  - SB: be=4'b0001<<addr[1:0], wdata=sdata[7:0] replicated x4.
  - SH: be=4'b0011<<(addr[1]*2), wdata=sdata[15:0] replicated x2.
  - SW: be=4'b1111.
  - mem_we=1. A store never writes back.
- Load outputs: mem_we=0, be=4'b1111.
  - On the ack cycle, the byte or half at addr[1:0] is extracted from mem_rdata.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - The cycle after ack: wb_we = in_wreg && rd!=0, wb_wdata = extended value.
- wb_we is a single-cycle pulse. When no writeback occurs, wb_we=0 and wb_waddr/wb_wdata hold their last values.
- rd=x0 never asserts wb_we.
- mem_ack while mem_req=0 is ignored.

Test Plan:
- Reset: assert rst 2 cycles mid-load (mem_req=1), then ack one cycle after rst falls -> mem_req=0 the cycle after rst, wb_we stays 0, in_ready=1.
- Back-to-back ALU: three ALU ops with rd=1,2,0 and results 0x11,0x22,0x33 on consecutive cycles -> wb_we pulses 1,1,0 on the following cycles with waddr 1,2 and wdata 0x11,0x22; in_ready always 1.
- LB at addr 0x103, mem_rdata=0x80FF_7F01, ack after 3 cycles -> mem_addr=0x100, be=1111, in_ready=0 for 3 cycles, wb_wdata=0xFFFF_FF80 one cycle after ack. Repeat with LBU -> 0x0000_0080.
- LH addr 0x202 with rdata=0x8001_1234 -> wb_wdata=0xFFFF_8001. LW addr 0x204 with rdata=0xDEAD_BEEF -> 0xDEAD_BEEF.
- SB addr 0x301 with sdata=0x1234_56AB -> be=0010, wdata=0xABAB_ABAB, mem_we=1, no wb_we. SH addr 0x302 -> be=1100, wdata=0x56AB_56AB.
- LW at addr 0x402 -> exc_misalign pulse 1 cycle, mem_req never rises, wb_we=0. Load with funct3=011 -> same response.
